// File: rtl/hex_parser.sv
// ASCII hex token parser: collects up to DIGITS hex characters and emits the
// right-aligned value on a terminator (CR, LF, space); malformed tokens emit an error.
module hex_parser #(
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   out_word,
  output logic [3:0]            out_ndigits,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int         W       = 4 * DIGITS;
  localparam logic [3:0] MAX_CNT = 4'(DIGITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2,
    EMIT    = 2'd3
  } state_t;

  // Returns {is_digit, is_term, nibble}; letters have low nibble 1..6, so add 9.
  function automatic logic [5:0] classify(input logic [7:0] c);
    logic [5:0] r;
    r = 6'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {2'b10, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {2'b10, c[3:0] + 4'd9};
    end else if (c == 8'h0D || c == 8'h0A || c == 8'h20) begin
      r = {2'b01, 4'd0};
    end else begin
      r = 6'd0;
    end
    return r;
  endfunction

  state_t         state_r, state_s;
  logic [W-1:0]   acc_r, acc_s, acc_shift_s;
  logic [3:0]     cnt_r, cnt_s;
  logic [W-1:0]   word_r, word_s;
  logic [3:0]     ndig_r, ndig_s;
  logic           err_r, err_s;
  logic           valid_r, valid_s;
  logic [5:0]     cls_s;
  logic           accept_s;

  assign in_ready    = (state_r != EMIT);
  assign out_word    = word_r;
  assign out_ndigits = ndig_r;
  assign out_err     = err_r;
  assign out_valid   = valid_r;

  // Next-state and result-register logic.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    word_s      = word_r;
    ndig_s      = ndig_r;
    err_s       = err_r;
    valid_s     = valid_r;
    cls_s       = classify(in_data);
    accept_s    = in_valid && (state_r != EMIT);
    acc_shift_s = acc_r << 3'd4;
    acc_shift_s[3:0] = cls_s[3:0];

    case (state_r)
      IDLE, ACCUM: begin
        if (!accept_s) begin
          state_s = state_r;
        end else if (cls_s[5]) begin
          if (cnt_r < MAX_CNT) begin
            acc_s   = acc_shift_s;
            cnt_s   = cnt_r + 4'd1;
            state_s = ACCUM;
          end else begin
            state_s = DISCARD;
          end
        end else if (cls_s[4]) begin
          // A terminator with no digits held is an empty token and is dropped.
          if (state_r == ACCUM) begin
            word_s  = acc_r;
            ndig_s  = cnt_r;
            err_s   = 1'b0;
            valid_s = 1'b1;
            state_s = EMIT;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = DISCARD;
        end
      end
      DISCARD: begin
        if (accept_s && cls_s[4]) begin
          word_s  = '0;
          ndig_s  = 4'd0;
          err_s   = 1'b1;
          valid_s = 1'b1;
          state_s = EMIT;
        end else begin
          state_s = DISCARD;
        end
      end
      EMIT: begin
        if (out_ready) begin
          valid_s = 1'b0;
          acc_s   = '0;
          cnt_s   = 4'd0;
          state_s = IDLE;
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s = IDLE;
        acc_s   = '0;
        cnt_s   = 4'd0;
        valid_s = 1'b0;
      end
    endcase
  end

  // State, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_r   <= '0;
      cnt_r   <= 4'd0;
      word_r  <= '0;
      ndig_r  <= 4'd0;
      err_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      word_r  <= word_s;
      ndig_r  <= ndig_s;
      err_r   <= err_s;
      valid_r <= valid_s;
    end
  end

endmodule

// File: tb/tb_hex_parser.sv
// Directed bench for hex_parser (DIGITS=8): each task drives one scenario and
// checks results gathered by a handshake monitor against hand-computed values.
module tb_hex_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_word;
  logic [3:0]  out_ndigits;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] w;
    logic [3:0]  n;
    logic        e;
  } res_t;
  res_t q[$];

  hex_parser #(.DIGITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_word(out_word), .out_ndigits(out_ndigits),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Record every result that will be handshaken at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q.push_back('{w: out_word, n: out_ndigits, e: out_err});
    end
  end

  task automatic send(input logic [7:0] c);
    int t;
    t = 0;
    @(negedge clk);
    in_data  = c;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      tests++; fails++;
      $display("FAIL send_timeout char=%h in_ready stuck at 0, required 1", c);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    #2;
    tests++;
    if (out_valid !== 1'b0 || out_word !== 32'h0 || out_ndigits !== 4'd0 ||
        out_err !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state got v=%b w=%h n=%0d e=%b r=%b, required 0 0 0 0 1",
               out_valid, out_word, out_ndigits, out_err, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    q.delete();
    send_str("dEaD1234");
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL basic_early_valid got %b, required 0", out_valid);
    end
    send(8'h0D);
    tests++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL basic_latency out_valid got %b, required 1", out_valid);
    end
    drain();
    tests++;
    if (q.size() != 1) begin
      fails++; $display("FAIL basic_count got %0d, required 1", q.size());
    end else begin
      tests++;
      if (q[0].w !== 32'hDEAD1234 || q[0].n !== 4'd8 || q[0].e !== 1'b0) begin
        fails++;
        $display("FAIL basic_value got %h/%0d/%b, required deadbeef-less DEAD1234/8/0",
                 q[0].w, q[0].n, q[0].e);
      end
    end
  endtask

  task automatic test_terminators();
    q.delete();
    send_str("7"); send(8'h0D); send(8'h0A); send(8'h20);
    send_str("a"); send(8'h20);
    drain();
    tests++;
    if (q.size() != 2) begin
      fails++; $display("FAIL term_count got %0d, required 2", q.size());
    end else begin
      tests++;
      if (q[0].w !== 32'h7 || q[0].n !== 4'd1 || q[0].e !== 1'b0) begin
        fails++; $display("FAIL term_first got %h/%0d/%b, required 7/1/0", q[0].w, q[0].n, q[0].e);
      end
      tests++;
      if (q[1].w !== 32'hA || q[1].n !== 4'd1 || q[1].e !== 1'b0) begin
        fails++; $display("FAIL term_second got %h/%0d/%b, required A/1/0", q[1].w, q[1].n, q[1].e);
      end
    end
  endtask

  task automatic test_illegal();
    q.delete();
    send_str("12G4"); send(8'h0A);
    send_str("5");    send(8'h0A);
    drain();
    tests++;
    if (q.size() != 2) begin
      fails++; $display("FAIL illegal_count got %0d, required 2", q.size());
    end else begin
      tests++;
      if (q[0].w !== 32'h0 || q[0].n !== 4'd0 || q[0].e !== 1'b1) begin
        fails++; $display("FAIL illegal_err got %h/%0d/%b, required 0/0/1", q[0].w, q[0].n, q[0].e);
      end
      tests++;
      if (q[1].w !== 32'h5 || q[1].n !== 4'd1 || q[1].e !== 1'b0) begin
        fails++; $display("FAIL illegal_recover got %h/%0d/%b, required 5/1/0", q[1].w, q[1].n, q[1].e);
      end
    end
  endtask

  task automatic test_overflow();
    q.delete();
    send_str("123456789"); send(8'h20);
    send_str("12345678");  send(8'h20);
    drain();
    tests++;
    if (q.size() != 2) begin
      fails++; $display("FAIL ovf_count got %0d, required 2", q.size());
    end else begin
      tests++;
      if (q[0].w !== 32'h0 || q[0].n !== 4'd0 || q[0].e !== 1'b1) begin
        fails++; $display("FAIL ovf_nine got %h/%0d/%b, required 0/0/1", q[0].w, q[0].n, q[0].e);
      end
      tests++;
      if (q[1].w !== 32'h12345678 || q[1].n !== 4'd8 || q[1].e !== 1'b0) begin
        fails++; $display("FAIL ovf_eight got %h/%0d/%b, required 12345678/8/0", q[1].w, q[1].n, q[1].e);
      end
    end
  endtask

  task automatic test_backpressure();
    q.delete();
    out_ready = 1'b0;
    send_str("3F"); send(8'h0D);
    in_data = 8'h39; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_word !== 32'h3F || out_ndigits !== 4'd2 ||
          out_err !== 1'b0 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cyc=%0d got v=%b w=%h n=%0d e=%b r=%b, required 1 3F 2 0 0",
                 i, out_valid, out_word, out_ndigits, out_err, in_ready);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release got v=%b r=%b, required 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    send(8'h0D);
    drain();
    tests++;
    if (q.size() != 2) begin
      fails++; $display("FAIL bp_count got %0d, required 2", q.size());
    end else begin
      tests++;
      if (q[0].w !== 32'h3F || q[1].w !== 32'h9 || q[1].n !== 4'd1 || q[1].e !== 1'b0) begin
        fails++;
        $display("FAIL bp_values got %h then %h/%0d/%b, required 3F then 9/1/0",
                 q[0].w, q[1].w, q[1].n, q[1].e);
      end
    end
  endtask

  task automatic test_reset_mid();
    q.delete();
    send_str("AB");
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_word !== 32'h0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid got v=%b w=%h r=%b, required 0 0 1", out_valid, out_word, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h0D);
    out_ready = 1'b0;
    send_str("E"); send(8'h0D);
    tests++;
    if (out_valid !== 1'b1 || out_word !== 32'hE) begin
      fails++; $display("FAIL rst_emit_pre got v=%b w=%h, required 1 E", out_valid, out_word);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_word !== 32'h0 || out_ndigits !== 4'd0 ||
        out_err !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_emit got v=%b w=%h n=%0d e=%b r=%b, required 0 0 0 0 1",
               out_valid, out_word, out_ndigits, out_err, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_str("C"); send(8'h0D);
    drain();
    tests++;
    if (q.size() != 1) begin
      fails++; $display("FAIL rst_count got %0d, required 1", q.size());
    end else begin
      tests++;
      if (q[0].w !== 32'hC || q[0].n !== 4'd1 || q[0].e !== 1'b0) begin
        fails++; $display("FAIL rst_after got %h/%0d/%b, required C/1/0", q[0].w, q[0].n, q[0].e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_terminators();
    test_illegal();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
